ref_synth: RTL and testbench
============================

// Module: ref_synth
// PURPOSE
//  Digital 800 Hz reference synthesiser and interrogate scheduler. It steps a phase counter on
//  each rising edge of the 51.2 kpps CLOCKH train and drives the reference square wave UREF1H.
//  A fixed phase delay after every reference half-cycle start, it issues one ISSIHI interrogate
//  pulse. An optional sync_in edge aligns and lock-checks the reference; used on TARGET_WEB builds.
// PARAMETERS
//  DIV         64   CLOCKH steps per reference cycle (51200/800); even, >= 8
//  INT_DELAY   16   steps from half-cycle start to ISSIHI (16*19.53us = 312.5us); 1..DIV/2-1
//  INT_WIDTH   15   ISSIHI width in clk cycles; must be < clk cycles per CLOCKH period
//  LOCK_CYCLES 4    consecutive on-time sync edges needed to assert locked; 1..15
//  FREE_RUN    0    1: go IDLE->RUN directly (skip ALIGN)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  synchronous reset, active low
//  en          in   1  run enable; low forces IDLE
//  CLOCKH      in   1  51.2 kpps pulse train, synchronous to clk; rising edge = one step
//  sync_in     in   1  external reference zero-crossing marker, synchronous; rising edge = phase 0
//  UREF1H      out  1  reference square wave, high for phase 0..DIV/2-1
//  ISSIHI      out  1  interrogate pulse, INT_WIDTH clk wide
//  ref_phase   out  6  current phase, 0..DIV-1 ($clog2(DIV) bits)
//  locked      out  1  LOCK_CYCLES consecutive sync edges landed on phase 0
//  slip_count  out  8  count of misaligned sync edges, saturates at 255
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, ref_phase=0, UREF1H=0, ISSIHI=0, locked=0,
//    slip_count=0, good count=0, edge-detect regs=0.
//  - step = CLOCKH & ~CLOCKH_q. sedge = sync_in & ~sync_q. Each is a 1-clk pulse.
//  - States:
//    - IDLE: all outputs low and ref_phase held at 0; slip_count holds.
//      en=1 -> ALIGN, or -> RUN with phase 0 if FREE_RUN=1.
//    - ALIGN: outputs low, phase 0. sedge -> RUN; the phase-0 half-cycle start occurs on that edge.
//    - RUN: step advances ref_phase by 1 and wraps DIV-1 -> 0.
//    - Any state: en=0 -> IDLE on the next edge; locked and good count clear; a running ISSIHI is cut.
//  - All outputs are registers, updated on the same edge as ref_phase.
//    - In RUN, UREF1H = (new phase < DIV/2).
//  - ISSIHI: a width counter loads INT_WIDTH on the edge where phase becomes INT_DELAY or
//    DIV/2+INT_DELAY, via step or via forced load. ISSIHI = (counter != 0).
//    Result: exactly 2 pulses per reference cycle.
//  - sync in RUN:
//    - sedge with ref_phase==0 and no step -> on time: good++ (saturates at LOCK_CYCLES);
//      locked=1 when good reaches LOCK_CYCLES.
//    - sedge with ref_phase!=0 -> slip: phase forced to 0, UREF1H=1, slip_count++ (saturating),
//      good=0, locked=0. The pending interrogate is rescheduled from the new phase 0;
//      an ISSIHI already high completes its width.
//    - sedge and step in the same clk: sync wins. Phase becomes 0, the step is dropped, and the
//      edge is on time iff the pre-step ref_phase was DIV-1, otherwise a slip.
//    - No sedge for 2*DIV steps while locked -> locked=0, good=0 (reference lost).
//  - The phase wrap DIV-1 -> 0 is the only half-cycle start at 0; DIV/2-1 -> DIV/2 is the other.
// TESTING
//  1. Reset with en=0 and CLOCKH toggling -> all outputs 0 and ref_phase stays 0 for 200 steps.
//  2. FREE_RUN=0, en=1, CLOCKH every 20 clk, sedge once -> UREF1H=1 for 32 steps then 0 for 32;
//     ISSIHI rises as phase hits 16 and 48; each pulse is exactly 15 clk; 2 pulses/cycle.
//  3. sedge every 64 steps, on time -> locked rises on the 4th on-time edge; slip_count stays 0.
//  4. While locked, sedge at ref_phase=37 -> phase=0, UREF1H=1, slip_count=1, locked=0.
//     The next ISSIHI comes 16 steps later; there is no ISSIHI at phase 48 of the aborted cycle.
//  5. sedge and step in the same clk: once with pre-phase 63 (on time, good++),
//     once with pre-phase 10 (slip) -> phase=0 in both cases, and the step is not counted.
//  6. Drop en mid-ISSIHI at pulse clk 5 -> next edge: IDLE, ISSIHI=0, locked=0, slip_count held.
//     Re-enable then sedge -> clean restart at phase 0. Also: 300 slips -> slip_count holds 255.

Source files
------------

// File: rtl/ref_synth.sv
// 800 Hz reference square-wave synthesiser with a phase-locked interrogate scheduler.
// The phase steps on CLOCKH rising edges, and sync_in edges align the phase and check lock.
module ref_synth #(
    parameter int DIV         = 64,
    parameter int INT_DELAY   = 16,
    parameter int INT_WIDTH   = 15,
    parameter int LOCK_CYCLES = 4,
    parameter int FREE_RUN    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    CLOCKH,
    input  logic                    sync_in,
    output logic                    UREF1H,
    output logic                    ISSIHI,
    output logic [$clog2(DIV)-1:0]  ref_phase,
    output logic                    locked,
    output logic [7:0]              slip_count
);
    localparam int PW = $clog2(DIV);
    localparam int WW = $clog2(INT_WIDTH + 1);
    localparam int LW = $clog2(2 * DIV + 1);

    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);
    localparam logic [PW-1:0] PH_INT0 = PW'(INT_DELAY);
    localparam logic [PW-1:0] PH_INT1 = PW'(DIV / 2 + INT_DELAY);
    localparam logic [WW-1:0] WIDTH_LOAD = WW'(INT_WIDTH);
    localparam logic [LW-1:0] LOST_MAX = LW'(2 * DIV);
    localparam logic [3:0]    GOOD_MAX = 4'(LOCK_CYCLES);

    typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d, phase_inc;
    logic            uref_q, uref_d;
    logic [WW-1:0]   width_q, width_d;
    logic            issihi_q;
    logic            locked_q, locked_d;
    logic [3:0]      good_q, good_d;
    logic [7:0]      slip_q, slip_d;
    logic [LW-1:0]   lost_q, lost_d;
    logic            clockh_q, sync_q;
    logic            step, sedge, on_time, load_int;

    assign step  = CLOCKH & ~clockh_q;
    assign sedge = sync_in & ~sync_q;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        uref_d    = uref_q;
        width_d   = (width_q != '0) ? width_q - 1'b1 : width_q;
        locked_d  = locked_q;
        good_d    = good_q;
        slip_d    = slip_q;
        lost_d    = lost_q;
        load_int  = 1'b0;
        phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        // A sync edge coinciding with a step is judged against the phase the step would have left.
        on_time   = step ? (phase_q == PH_LAST) : (phase_q == '0);

        case (state_q)
            IDLE: begin
                phase_d = '0;
                uref_d  = 1'b0;
                width_d = '0;
                lost_d  = '0;
                if (FREE_RUN != 0) begin
                    state_d = RUN;
                    uref_d  = 1'b1;
                end else begin
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                phase_d = '0;
                uref_d  = 1'b0;
                width_d = '0;
                lost_d  = '0;
                if (sedge) begin
                    state_d = RUN;
                    uref_d  = 1'b1;
                end
            end
            RUN: begin
                if (sedge) begin
                    phase_d = '0;
                    uref_d  = 1'b1;
                    lost_d  = '0;
                    if (on_time) begin
                        if (good_q != GOOD_MAX) good_d = good_q + 1'b1;
                        if (good_d == GOOD_MAX) locked_d = 1'b1;
                    end else begin
                        if (slip_q != 8'hFF) slip_d = slip_q + 1'b1;
                        good_d   = '0;
                        locked_d = 1'b0;
                    end
                end else if (step) begin
                    phase_d  = phase_inc;
                    uref_d   = (phase_inc < PH_HALF);
                    load_int = (phase_inc == PH_INT0) || (phase_inc == PH_INT1);
                    if (lost_q != LOST_MAX) lost_d = lost_q + 1'b1;
                    if (locked_q && lost_d == LOST_MAX) begin
                        locked_d = 1'b0;
                        good_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_int) width_d = WIDTH_LOAD;

        if (!en) begin
            state_d  = IDLE;
            phase_d  = '0;
            uref_d   = 1'b0;
            width_d  = '0;
            locked_d = 1'b0;
            good_d   = '0;
            lost_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            uref_q   <= 1'b0;
            width_q  <= '0;
            issihi_q <= 1'b0;
            locked_q <= 1'b0;
            good_q   <= '0;
            slip_q   <= '0;
            lost_q   <= '0;
            clockh_q <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            uref_q   <= uref_d;
            width_q  <= width_d;
            issihi_q <= (width_d != '0);
            locked_q <= locked_d;
            good_q   <= good_d;
            slip_q   <= slip_d;
            lost_q   <= lost_d;
            clockh_q <= CLOCKH;
            sync_q   <= sync_in;
        end
    end

    assign UREF1H     = uref_q;
    assign ISSIHI     = issihi_q;
    assign ref_phase  = phase_q;
    assign locked     = locked_q;
    assign slip_count = slip_q;
endmodule

// File: tb/tb_ref_synth.sv
// Directed bench for ref_synth: expected interrogate pulses are queued as steps are driven
// and matched against the pulses observed on ISSIHI.
module tb_ref_synth;
    localparam int DIV         = 64;
    localparam int INT_DELAY   = 16;
    localparam int INT_WIDTH   = 15;
    localparam int LOCK_CYCLES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       CLOCKH = 1'b0;
    logic       sync_in = 1'b0;
    logic       UREF1H, ISSIHI, locked;
    logic [5:0] ref_phase;
    logic [7:0] slip_count;

    ref_synth #(
        .DIV(DIV), .INT_DELAY(INT_DELAY), .INT_WIDTH(INT_WIDTH),
        .LOCK_CYCLES(LOCK_CYCLES), .FREE_RUN(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .CLOCKH(CLOCKH), .sync_in(sync_in),
        .UREF1H(UREF1H), .ISSIHI(ISSIHI), .ref_phase(ref_phase),
        .locked(locked), .slip_count(slip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int width;
    } pulse_t;

    pulse_t exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     exp_phase = 0;
    bit     exp_run = 1'b0;
    int     exp_good = 0;
    bit     exp_locked = 1'b0;
    int     exp_slip = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_step(input int wid = INT_WIDTH);
        CLOCKH = 1'b1;
        cyc();
        CLOCKH = 1'b0;
        if (exp_run) begin
            exp_phase = (exp_phase + 1) % DIV;
            if (exp_phase == INT_DELAY || exp_phase == DIV / 2 + INT_DELAY)
                exp_q.push_back('{phase: exp_phase, width: wid});
        end
        check("step_phase", ref_phase, exp_phase);
        check("step_uref", UREF1H, exp_run && (exp_phase < DIV / 2));
    endtask

    task automatic do_sync(input bit with_step);
        bit on_time;
        sync_in = 1'b1;
        CLOCKH  = with_step;
        cyc();
        sync_in = 1'b0;
        CLOCKH  = 1'b0;
        if (!exp_run) begin
            exp_run = 1'b1;
        end else begin
            on_time = with_step ? (exp_phase == DIV - 1) : (exp_phase == 0);
            if (on_time) begin
                if (exp_good < LOCK_CYCLES) exp_good++;
                if (exp_good == LOCK_CYCLES) exp_locked = 1'b1;
            end else begin
                if (exp_slip < 255) exp_slip++;
                exp_good   = 0;
                exp_locked = 1'b0;
            end
        end
        exp_phase = 0;
        check("sync_phase", ref_phase, 0);
        check("sync_uref", UREF1H, 1);
        check("sync_locked", locked, exp_locked);
        check("sync_slip", slip_count, exp_slip);
    endtask

    // Pulse monitor: measures each ISSIHI pulse and matches it against the queue head.
    bit mon_prev = 1'b0;
    int mon_width = 0;
    int mon_phase = 0;
    always @(negedge clk) begin
        if (ISSIHI === 1'b1) begin
            if (!mon_prev) begin
                mon_phase = int'(ref_phase);
                mon_width = 0;
            end
            mon_width++;
            mon_prev = 1'b1;
        end else if (mon_prev) begin
            mon_prev = 1'b0;
            check("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                pulse_t p;
                p = exp_q.pop_front();
                check("pulse_phase", mon_phase, p.phase);
                check("pulse_width", mon_width, p.width);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle(3);
        check("rst_phase", ref_phase, 0);
        check("rst_uref", UREF1H, 0);
        check("rst_issihi", ISSIHI, 0);
        check("rst_locked", locked, 0);
        check("rst_slip", slip_count, 0);
        rst_n = 1'b1;

        // Disabled: CLOCKH activity must not move the phase.
        for (int i = 0; i < 200; i++) begin
            do_step();
            idle(1);
        end
        check("idle_issihi", ISSIHI, 0);

        // Enable without sync: waits in ALIGN with outputs low.
        en = 1'b1;
        idle(3);
        check("align_phase", ref_phase, 0);
        check("align_uref", UREF1H, 0);
        do_sync(1'b0);
        idle(19);

        // Four full cycles, each ended by an on-time sync; locked rises on the fourth.
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < DIV; s++) begin
                do_step();
                idle(19);
            end
            do_sync(1'b0);
            idle(19);
        end
        check("locked_after_4", locked, 1);

        // Slip at phase 37 aborts the cycle; next interrogate comes 16 steps later.
        for (int s = 0; s < 37; s++) begin
            do_step();
            idle(19);
        end
        do_sync(1'b0);
        idle(19);
        for (int s = 0; s < 20; s++) begin
            do_step();
            idle(19);
        end

        // Sync coincident with step: on time from 63, slip from 10.
        while (exp_phase != DIV - 1) begin
            do_step();
            idle(19);
        end
        do_sync(1'b1);
        idle(19);
        do_step();
        idle(19);
        for (int s = 0; s < 9; s++) begin
            do_step();
            idle(19);
        end
        do_sync(1'b1);
        idle(19);

        // Drop enable at the fifth clock of an interrogate pulse.
        for (int s = 0; s < INT_DELAY - 1; s++) begin
            do_step();
            idle(19);
        end
        do_step(5);
        idle(4);
        en = 1'b0;
        cyc();
        exp_run    = 1'b0;
        exp_phase  = 0;
        exp_good   = 0;
        exp_locked = 1'b0;
        check("dis_issihi", ISSIHI, 0);
        check("dis_locked", locked, 0);
        check("dis_slip", slip_count, exp_slip);
        check("dis_phase", ref_phase, 0);
        check("dis_uref", UREF1H, 0);
        idle(5);

        // Clean restart.
        en = 1'b1;
        idle(3);
        do_sync(1'b0);
        idle(19);
        for (int s = 0; s < 20; s++) begin
            do_step();
            idle(19);
        end

        // Slip counter saturation.
        for (int i = 0; i < 300; i++) begin
            do_step();
            do_sync(1'b0);
        end
        check("slip_saturated", slip_count, 255);

        idle(30);
        check("pulses_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
